// File: rtl/audio_pkg.sv
// Shared constants and helpers for the serial-audio receive path.
package audio_pkg;

  localparam int unsigned MODE_LJ  = 0;
  localparam int unsigned MODE_I2S = 1;
  localparam int unsigned FS_FALL  = 0;
  localparam int unsigned FS_RISE  = 1;

  // Width of a counter that must be able to hold the value max_val itself.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/audio_sync_delay.sv
// Multi-flop synchroniser/delay line; LRCLK and ADCDAT use identical depths so they stay aligned.
module audio_sync_delay #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] chain_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[Stages-2:0], d_i};
    end
  end

  assign q_o = chain_q[Stages-1];

endmodule

// File: rtl/audio_rx_tdm.sv
// Serial-audio receiver (I2S / left-justified, stereo or TDM) in the BCLK domain.
module audio_rx_tdm
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SLOT_W      = 32,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned MODE        = 1,
  parameter int unsigned FS_EDGE     = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     BCLK,
  input  logic                     rst_n,
  input  logic                     LRCLK,
  input  logic                     ADCDAT,
  output logic [NUM_CH*DATA_W-1:0] data,
  output logic                     frame_valid,
  output logic                     locked,
  output logic                     frame_err
);

  localparam int unsigned FrameLen  = NUM_CH * SLOT_W;
  localparam int unsigned CommitPos = (NUM_CH - 1) * SLOT_W + MODE + DATA_W - 1;
  localparam int unsigned CntW      = cnt_width(FrameLen);
  localparam int unsigned OffW      = cnt_width(SLOT_W);
  localparam int unsigned SlotW     = cnt_width(NUM_CH);

  if (SLOT_W < DATA_W + MODE || NUM_CH < 1 || SYNC_STAGES < 2 || MODE > MODE_I2S ||
      FS_EDGE > FS_RISE) begin : gen_bad_params
    $error("audio_rx_tdm: illegal parameter combination");
  end

  logic lr_s, dat_s, lr_q, fs;

  audio_sync_delay #(.Stages(SYNC_STAGES)) u_sync_lr (
    .clk_i  (BCLK),
    .rst_ni (rst_n),
    .d_i    (LRCLK),
    .q_o    (lr_s)
  );

  audio_sync_delay #(.Stages(SYNC_STAGES)) u_sync_dat (
    .clk_i  (BCLK),
    .rst_ni (rst_n),
    .d_i    (ADCDAT),
    .q_o    (dat_s)
  );

  assign fs = (FS_EDGE == FS_RISE) ? (lr_s & ~lr_q) : (~lr_s & lr_q);

  logic [CntW-1:0]   cnt_q, cur_pos;
  logic [OffW-1:0]   off_q, cur_off;
  logic [SlotW-1:0]  slot_q, cur_slot;
  logic              locked_q, locked_d, fv_q, fv_d, fe_q, fe_d;
  logic              in_frame, in_window;
  logic [DATA_W-1:0] shadow_q [NUM_CH];
  logic [DATA_W-1:0] shadow_d [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] data_q, data_d;

  // Position of the bit currently at the end of the sync pipeline; off/slot track pos mod SLOT_W.
  always_comb begin
    cur_pos  = cnt_q;
    cur_off  = off_q;
    cur_slot = slot_q;
    if (fs) begin
      cur_pos  = '0;
      cur_off  = '0;
      cur_slot = '0;
    end else if (cnt_q != CntW'(FrameLen)) begin
      cur_pos = cnt_q + CntW'(1);
      if (off_q == OffW'(SLOT_W - 1)) begin
        cur_off  = '0;
        cur_slot = slot_q + SlotW'(1);
      end else begin
        cur_off = off_q + OffW'(1);
      end
    end
  end

  assign in_frame  = (cur_pos != CntW'(FrameLen));
  assign in_window = in_frame && (int'(cur_off) >= int'(MODE)) &&
                     (int'(cur_off) < int'(MODE + DATA_W));

  always_comb begin
    shadow_d = shadow_q;
    data_d   = data_q;
    for (int unsigned s = 0; s < NUM_CH; s++) begin
      if (in_window && cur_slot == SlotW'(s)) begin
        shadow_d[s] = DATA_W'({shadow_q[s], dat_s});
      end
    end
    fv_d = in_frame && (cur_pos == CntW'(CommitPos)) && locked_q;
    // Commit takes the shadow words including the bit captured this cycle.
    if (fv_d) begin
      for (int unsigned s = 0; s < NUM_CH; s++) begin
        data_d[s*DATA_W +: DATA_W] = shadow_d[s];
      end
    end
    fe_d     = fs && locked_q && (cnt_q != CntW'(FrameLen - 1));
    locked_d = locked_q | fs;
  end

  always_ff @(posedge BCLK or negedge rst_n) begin
    if (!rst_n) begin
      lr_q     <= 1'b0;
      cnt_q    <= '0;
      off_q    <= '0;
      slot_q   <= '0;
      locked_q <= 1'b0;
      fv_q     <= 1'b0;
      fe_q     <= 1'b0;
      data_q   <= '0;
      for (int unsigned s = 0; s < NUM_CH; s++) begin
        shadow_q[s] <= '0;
      end
    end else begin
      lr_q     <= lr_s;
      cnt_q    <= cur_pos;
      off_q    <= cur_off;
      slot_q   <= cur_slot;
      locked_q <= locked_d;
      fv_q     <= fv_d;
      fe_q     <= fe_d;
      data_q   <= data_d;
      shadow_q <= shadow_d;
    end
  end

  assign data        = data_q;
  assign frame_valid = fv_q;
  assign locked      = locked_q;
  assign frame_err   = fe_q;

endmodule

// File: tb/tb_audio_rx_tdm.sv
// Randomised bench for audio_rx_tdm: three configurations driven in turn, checked per cycle.
module tb_audio_rx_tdm;

  logic        bclk = 1'b0;
  logic        rst_n;
  logic [2:0]  lr, dat, fv, lk, fe;
  logic [31:0] data_a, data_b;
  logic [95:0] data_c;

  int n_vec = 0;
  int n_err = 0;

  // Per-configuration parameters: 0 = default I2S stereo, 1 = LJ tight slot, 2 = TDM I2S rising.
  int c_dw   [3] = '{16, 16, 24};
  int c_sw   [3] = '{32, 16, 32};
  int c_nch  [3] = '{2, 2, 4};
  int c_mode [3] = '{1, 0, 1};
  int c_fse  [3] = '{0, 0, 1};
  int c_sync [3] = '{2, 2, 3};

  bit s_lr[$];
  bit s_dat[$];

  always #5 bclk = ~bclk;

  audio_rx_tdm u_dut_a (
    .BCLK(bclk), .rst_n(rst_n), .LRCLK(lr[0]), .ADCDAT(dat[0]),
    .data(data_a), .frame_valid(fv[0]), .locked(lk[0]), .frame_err(fe[0])
  );

  audio_rx_tdm #(.MODE(0), .SLOT_W(16)) u_dut_b (
    .BCLK(bclk), .rst_n(rst_n), .LRCLK(lr[1]), .ADCDAT(dat[1]),
    .data(data_b), .frame_valid(fv[1]), .locked(lk[1]), .frame_err(fe[1])
  );

  audio_rx_tdm #(.DATA_W(24), .NUM_CH(4), .FS_EDGE(1), .SYNC_STAGES(3)) u_dut_c (
    .BCLK(bclk), .rst_n(rst_n), .LRCLK(lr[2]), .ADCDAT(dat[2]),
    .data(data_c), .frame_valid(fv[2]), .locked(lk[2]), .frame_err(fe[2])
  );

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [95:0] obs_data(input int sel);
    case (sel)
      0:       return {64'b0, data_a};
      1:       return {64'b0, data_b};
      default: return data_c;
    endcase
  endfunction

  task automatic push_idle(input int sel, input int cycles);
    repeat (cycles) begin
      s_lr.push_back(c_fse[sel] == 0);
      s_dat.push_back(1'($urandom));
    end
  endtask

  // One frame of len BCLKs (only the first cut are emitted); words placed per the framing rules.
  task automatic push_frame(input int sel, input int len, input int cut, input logic [23:0] w [4]);
    for (int p = 0; p < cut; p++) begin
      int s;
      int off;
      bit b;
      s   = p / c_sw[sel];
      off = p % c_sw[sel];
      b   = 1'($urandom);
      if (s < c_nch[sel] && off >= c_mode[sel] && off < c_mode[sel] + c_dw[sel])
        b = w[s][c_dw[sel] - 1 - (off - c_mode[sel])];
      s_lr.push_back((p < len / 2) == (c_fse[sel] != 0));
      s_dat.push_back(b);
    end
  endtask

  task automatic rand_frame(input int sel, input int len, input int cut);
    logic [23:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = 24'($urandom);
    push_frame(sel, len, cut, w);
  endtask

  task automatic full_frames(input int sel, input int count);
    repeat (count) rand_frame(sel, c_nch[sel] * c_sw[sel], c_nch[sel] * c_sw[sel]);
  endtask

  // Reference: find frame starts in the pin stream, slice words by position, derive pulses.
  task automatic run_stream(input int sel);
    int n  = s_lr.size();
    int sd = c_sync[sel];
    int fl = c_nch[sel] * c_sw[sel];
    int cp = (c_nch[sel] - 1) * c_sw[sel] + c_mode[sel] + c_dw[sel] - 1;
    int fs[$];
    bit prev = 1'b0;
    bit efv[];
    bit efe[];
    bit elk[];
    logic [95:0] edat[];
    efv  = new[n];
    efe  = new[n];
    elk  = new[n];
    edat = new[n];
    for (int t = 0; t < n; t++) edat[t] = '0;
    for (int t = 0; t < n; t++) begin
      if (s_lr[t] != prev && s_lr[t] == (c_fse[sel] != 0)) fs.push_back(t);
      prev = s_lr[t];
    end
    for (int i = 0; i < fs.size(); i++) begin
      int f;
      int nxt;
      logic [95:0] word;
      f   = fs[i];
      nxt = (i + 1 < fs.size()) ? fs[i+1] : n;
      if (i > 0 && f - fs[i-1] != fl && f + sd < n) efe[f+sd] = 1'b1;
      if (i == 0) for (int e = f + sd; e < n; e++) elk[e] = 1'b1;
      if (f + cp < nxt && f + cp + sd < n) begin
        word = '0;
        for (int s = 0; s < c_nch[sel]; s++)
          for (int k = 0; k < c_dw[sel]; k++)
            word[s*c_dw[sel] + c_dw[sel] - 1 - k] = s_dat[f + s*c_sw[sel] + c_mode[sel] + k];
        efv[f+cp+sd] = 1'b1;
        for (int e = f + cp + sd; e < n; e++) edat[e] = word;
      end
    end
    @(negedge bclk);
    rst_n = 1'b1;
    for (int e = 0; e < n; e++) begin
      lr[sel]  = s_lr[e];
      dat[sel] = s_dat[e];
      @(negedge bclk);
      check_eq("frame_valid", 96'(fv[sel]), 96'(efv[e]));
      check_eq("frame_err", 96'(fe[sel]), 96'(efe[e]));
      check_eq("locked", 96'(lk[sel]), 96'(elk[e]));
      check_eq("data", obs_data(sel), edat[e]);
    end
    s_lr.delete();
    s_dat.delete();
  endtask

  // Asynchronous reset in the middle of a BCLK low phase; outputs must clear at once.
  task automatic reset_check();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_data_a", {64'b0, data_a}, '0);
    check_eq("rst_data_b", {64'b0, data_b}, '0);
    check_eq("rst_data_c", data_c, '0);
    check_eq("rst_flags", 96'({fv, lk, fe}), '0);
    lr  = '0;
    dat = '0;
  endtask

  initial begin
    logic [23:0] w [4];
    lr    = '0;
    dat   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge bclk);
    reset_check();

    // Default I2S stereo: fixed words, short/very short frames, static LRCLK, mid-slot end.
    push_idle(0, 20);
    w = '{24'h8001, 24'h7FFE, 24'h0, 24'h0};
    push_frame(0, 64, 64, w);
    full_frames(0, 3);
    rand_frame(0, 61, 61);
    rand_frame(0, 40, 40);
    full_frames(0, 2);
    push_idle(0, 3 * 64);
    full_frames(0, 2);
    rand_frame(0, 64, 40);
    run_stream(0);
    reset_check();

    // Left-justified, slot exactly DATA_W wide: commit lands on the last bit of the frame.
    push_idle(1, 20);
    w = '{24'h8001, 24'h7FFE, 24'h0, 24'h0};
    push_frame(1, 32, 32, w);
    full_frames(1, 3);
    rand_frame(1, 29, 29);
    full_frames(1, 2);
    push_idle(1, 3 * 32);
    full_frames(1, 2);
    push_idle(1, 8);
    run_stream(1);
    reset_check();

    // 4-channel TDM, 24-bit words in 32-bit slots, rising frame start, 3-stage sync.
    push_idle(2, 20);
    w = '{24'h800000, 24'h7FFFFF, 24'h000001, 24'hFFFFFF};
    push_frame(2, 128, 128, w);
    full_frames(2, 2);
    rand_frame(2, 125, 125);
    full_frames(2, 1);
    rand_frame(2, 100, 100);
    full_frames(2, 2);
    push_idle(2, 3 * 128);
    full_frames(2, 1);
    rand_frame(2, 128, 50);
    run_stream(2);
    reset_check();

    // Recovery after a mid-slot reset.
    push_idle(0, 7);
    full_frames(0, 2);
    push_idle(0, 6);
    run_stream(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
